noc_vc_input_flow_ctrl: RTL and testbench

//   Router input-port flow control with per-virtual-channel flit buffering.

---
 rtl/noc_fc_pkg.sv | 18 +
 rtl/noc_vc_fifo.sv | 59 +++++
 rtl/noc_vc_input_flow_ctrl.sv | 106 ++++++++++
 tb/tb_noc_vc_input_flow_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_fc_pkg.sv
// Shared constants and helpers for the NoC VC input flow-control block.
// Optional retry statistics counter is enabled with macro NOC_FC_STATS_EN.
package noc_fc_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NUM_VC_DEF = 2;
    localparam int unsigned DEPTH_DEF  = 4;

    // Flit control bits, counted down from the MSB of the flit, for downstream users
    localparam int unsigned FLIT_HEAD_OFS = 0;
    localparam int unsigned FLIT_TAIL_OFS = 1;

    // VC index width; a single-VC build still carries a 1-bit index
    function automatic int unsigned vc_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-clock first-word-fall-through FIFO holding the flits of one VC.
// A push on a full FIFO is taken only when a pop happens in the same cycle.
module noc_vc_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    // Qualify requests against occupancy; a full FIFO frees its head slot on pop
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Flit storage; contents are meaningless while the matching count is zero
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/noc_vc_input_flow_ctrl.sv
// Router input-port flow control: per-VC flit buffering, retry, credit return.
// Define NOC_FC_STATS_EN to add the saturating ovf_cnt retry-event counter port.
module noc_vc_input_flow_ctrl
    import noc_fc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NUM_VC = NUM_VC_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_val,
    input  logic [vc_width(NUM_VC)-1:0]   in_vc,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_retry,
    output logic                          in_write,
    output logic [NUM_VC-1:0]             credit_ret,
    input  logic                          rd_en,
    input  logic [vc_width(NUM_VC)-1:0]   rd_vc,
    output logic [DATA_W-1:0]             rd_data,
    output logic [NUM_VC-1:0]             vc_empty,
    output logic [NUM_VC-1:0]             vc_full,
`ifdef NOC_FC_STATS_EN
    output logic [15:0]                   ovf_cnt,
`endif
    output logic                          ovf_err
);

    localparam int unsigned VC_W   = vc_width(NUM_VC);
    localparam int unsigned NV_EXT = 1 << VC_W;

    logic [NV_EXT-1:0] full_ext;
    logic [NV_EXT-1:0] empty_ext;
    logic [DATA_W-1:0] dout_ext [NV_EXT];
    logic [DATA_W-1:0] fifo_dout [NUM_VC];
    logic [NUM_VC-1:0] push_vec;
    logic [NUM_VC-1:0] pop_vec;
    logic              accept_c;

    // Out-of-range VC indices look full and empty, so they never write or pop
    always_comb begin
        full_ext  = '1;
        empty_ext = '1;
        full_ext[NUM_VC-1:0]  = vc_full;
        empty_ext[NUM_VC-1:0] = vc_empty;
        for (int v = 0; v < int'(NV_EXT); v++) begin
            dout_ext[v] = '0;
        end
        for (int v = 0; v < int'(NUM_VC); v++) begin
            dout_ext[v] = fifo_dout[v];
        end
    end

    // Accept when target VC has room, or is freeing its head this same cycle
    always_comb begin
        accept_c = in_val & (~full_ext[in_vc] |
                             (rd_en & (rd_vc == in_vc) & ~empty_ext[rd_vc]));
    end

    assign in_write = accept_c;
    assign in_retry = in_val & ~accept_c;
    assign rd_data  = dout_ext[rd_vc];

    // Per-VC FIFOs with decoded push/pop strobes
    for (genvar g = 0; g < int'(NUM_VC); g++) begin : g_vc
        assign push_vec[g] = accept_c & (in_vc == VC_W'(g));
        assign pop_vec[g]  = rd_en & (rd_vc == VC_W'(g)) & ~vc_empty[g];

        noc_vc_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_vec[g]),
            .pop   (pop_vec[g]),
            .din   (in_data),
            .dout  (fifo_dout[g]),
            .empty (vc_empty[g]),
            .full  (vc_full[g])
        );
    end

    // One-cycle credit pulse per valid pop and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_ret <= '0;
            ovf_err    <= 1'b0;
        end else begin
            credit_ret <= pop_vec;
            ovf_err    <= ovf_err | in_retry;
        end
    end

`ifdef NOC_FC_STATS_EN
    // Saturating count of retry cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (in_retry && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_vc_input_flow_ctrl.sv
// Directed self-checking bench for noc_vc_input_flow_ctrl (2 VCs, depth 4, 32-bit flits).
module tb_noc_vc_input_flow_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_val;
    logic [0:0]  in_vc;
    logic [31:0] in_data;
    logic        in_retry;
    logic        in_write;
    logic [1:0]  credit_ret;
    logic        rd_en;
    logic [0:0]  rd_vc;
    logic [31:0] rd_data;
    logic [1:0]  vc_empty;
    logic [1:0]  vc_full;
    logic        ovf_err;
`ifdef NOC_FC_STATS_EN
    logic [15:0] ovf_cnt;
`endif

    int errors = 0;
    int checks = 0;

    noc_vc_input_flow_ctrl #(
        .DATA_W (32),
        .NUM_VC (2),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_val     (in_val),
        .in_vc      (in_vc),
        .in_data    (in_data),
        .in_retry   (in_retry),
        .in_write   (in_write),
        .credit_ret (credit_ret),
        .rd_en      (rd_en),
        .rd_vc      (rd_vc),
        .rd_data    (rd_data),
        .vc_empty   (vc_empty),
        .vc_full    (vc_full),
`ifdef NOC_FC_STATS_EN
        .ovf_cnt    (ovf_cnt),
`endif
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp0 [7];

    initial begin
        exp0 = '{32'hA5, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60};
        rst_n = 1'b0; in_val = 1'b0; in_vc = '0; in_data = '0; rd_en = 1'b0; rd_vc = '0;
        step(); step();
        chk("rst_empty", 32'(vc_empty), 32'h3);
        chk("rst_full", 32'(vc_full), 32'h0);
        chk("rst_credit", 32'(credit_ret), 32'h0);
        chk("rst_ovf", 32'(ovf_err), 32'h0);
`ifdef NOC_FC_STATS_EN
        chk("rst_cnt", 32'(ovf_cnt), 32'h0);
`endif
        rst_n = 1'b1;
        step();

        // 1: single write to VC0
        in_val = 1'b1; in_vc = 1'd0; in_data = 32'hA5;
        #1;
        chk("t1_write", 32'(in_write), 32'h1);
        chk("t1_retry", 32'(in_retry), 32'h0);
        step();
        in_val = 1'b0; rd_vc = 1'd0;
        #1;
        chk("t1_empty", 32'(vc_empty), 32'h2);
        chk("t1_rdata", rd_data, 32'hA5);

        // 2: fill VC1, then overflow attempt
        for (int i = 1; i <= 4; i++) begin
            in_val = 1'b1; in_vc = 1'd1; in_data = 32'(i);
            #1;
            chk("t2_write", 32'(in_write), 32'h1);
            step();
        end
        in_val = 1'b0;
        #1;
        chk("t2_full", 32'(vc_full), 32'h2);
        in_val = 1'b1; in_vc = 1'd1; in_data = 32'd5;
        #1;
        chk("t2_retry", 32'(in_retry), 32'h1);
        chk("t2_nowrite", 32'(in_write), 32'h0);
        step();
        in_val = 1'b0; rd_vc = 1'd1;
        #1;
        chk("t2_ovf", 32'(ovf_err), 32'h1);
        chk("t2_noretry", 32'(in_retry), 32'h0);
`ifdef NOC_FC_STATS_EN
        chk("t2_cnt", 32'(ovf_cnt), 32'h1);
`endif

        // 3: pass-through write on a full VC
        in_val = 1'b1; in_vc = 1'd1; in_data = 32'd5; rd_en = 1'b1; rd_vc = 1'd1;
        #1;
        chk("t3_write", 32'(in_write), 32'h1);
        chk("t3_head", rd_data, 32'd1);
        step();
        in_val = 1'b0; rd_en = 1'b0;
        #1;
        chk("t3_full", 32'(vc_full), 32'h2);
        chk("t3_head2", rd_data, 32'd2);
        chk("t3_credit", 32'(credit_ret), 32'h2);
        step();
        chk("t3_credit_off", 32'(credit_ret), 32'h0);

        // 4: drain VC1
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; rd_vc = 1'd1;
            #1;
            chk("t4_data", rd_data, 32'(i + 2));
            chk("t4_credit", 32'(credit_ret), (i == 0) ? 32'h0 : 32'h2);
            step();
        end
        rd_en = 1'b0;
        #1;
        chk("t4_last_credit", 32'(credit_ret), 32'h2);
        chk("t4_empty", 32'(vc_empty), 32'h2);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        #1;
        chk("t4_no_credit", 32'(credit_ret), 32'h0);
        chk("t4_still_empty", 32'(vc_empty), 32'h2);

        // 5: park two flits on VC1, then wrap VC0 pointers
        for (int i = 0; i < 2; i++) begin
            in_val = 1'b1; in_vc = 1'd1; in_data = (i == 0) ? 32'h11 : 32'h22;
            step();
        end
        for (int i = 1; i <= 3; i++) begin
            in_val = 1'b1; in_vc = 1'd0; in_data = 32'(i * 16);
            #1;
            chk("t5_fill", 32'(in_write), 32'h1);
            step();
        end
        in_val = 1'b0;
        #1;
        chk("t5_full", 32'(vc_full), 32'h1);
        for (int k = 0; k < 3; k++) begin
            in_val = 1'b1; in_vc = 1'd0; in_data = 32'((k + 4) * 16);
            rd_en = 1'b1; rd_vc = 1'd0;
            #1;
            chk("t5_pt_write", 32'(in_write), 32'h1);
            chk("t5_pt_data", rd_data, exp0[k]);
            step();
            chk("t5_pt_credit", 32'(credit_ret), 32'h1);
        end
        in_val = 1'b0;
        for (int k = 3; k < 7; k++) begin
            rd_en = 1'b1; rd_vc = 1'd0;
            #1;
            chk("t5_drain", rd_data, exp0[k]);
            step();
            chk("t5_drain_credit", 32'(credit_ret), 32'h1);
        end
        rd_en = 1'b0;
        #1;
        chk("t5_empty", 32'(vc_empty), 32'h1);
        rd_vc = 1'd1;
        #1;
        chk("t5_vc1_head", rd_data, 32'h11);
        chk("t5_full_none", 32'(vc_full), 32'h0);

        // 6: async reset with data buffered and a credit pending
        in_val = 1'b1; in_vc = 1'd0; in_data = 32'h77; rd_en = 1'b1; rd_vc = 1'd1;
        step();
        in_val = 1'b0; rd_en = 1'b0;
        chk("t6_pre_credit", 32'(credit_ret), 32'h2);
        chk("t6_pre_empty", 32'(vc_empty), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("t6_empty", 32'(vc_empty), 32'h3);
        chk("t6_credit", 32'(credit_ret), 32'h0);
        chk("t6_ovf", 32'(ovf_err), 32'h0);
        chk("t6_full", 32'(vc_full), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_post_empty", 32'(vc_empty), 32'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
